// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and pointer/flag controller for a shared external FIFO array.
// The array writes on the clock edge and reads combinationally at b_rptr.
module fifo_wr_arbiter #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned N_REQ      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          r_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          w_en,
  output logic [PTR_WIDTH:0]            b_wptr,
  output logic [PTR_WIDTH:0]            b_rptr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          full,
  output logic                          empty,
  output logic [PTR_WIDTH:0]            count,
  output logic [$clog2(N_REQ)-1:0]      last_src,
  output logic                          underflow_err
);

  localparam int unsigned PW    = PTR_WIDTH + 1;
  localparam int unsigned SRC_W = $clog2(N_REQ);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [SRC_W-1:0] prio_q, prio_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic             uflow_q, uflow_d;

  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             accept;

  // Status comes from the registered pointers only.
  assign count    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (count == PW'(DEPTH));
  assign rd_valid = !empty;
  assign rd_data  = mem_rdata;

  assign b_wptr        = wptr_q;
  assign b_rptr        = rptr_q;
  assign last_src      = last_q;
  assign underflow_err = uflow_q;

  // Search from the priority index, wrapping modulo N_REQ; first valid requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = SRC_W'((32'(prio_q) + k) % N_REQ);
      if (!gnt_valid && req_valid[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    accept = gnt_valid && !full && rst_n;
  end

  assign req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
  assign w_en      = accept;
  assign mem_wdata = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    prio_d  = prio_q;
    last_d  = last_q;
    uflow_d = uflow_q;
    if (accept) begin
      wptr_d = wptr_q + PW'(1);
      prio_d = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      last_d = gnt_idx;
    end
    // A pop on an empty FIFO is dropped and latched as an error.
    if (r_en) begin
      if (!empty) rptr_d  = rptr_q + PW'(1);
      else        uflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      prio_q  <= '0;
      last_q  <= '0;
      uflow_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      prio_q  <= prio_d;
      last_q  <= last_d;
      uflow_q <= uflow_d;
    end
  end

endmodule
